// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: load/store unit for the MEM stage.
// Converts EX/MEM load/store control into a req/ack transaction on a word-wide
// data memory. It formats load data (lane select plus sign or zero extension)
// and generates the byte enables and replicated store data. While a transaction
// is in flight it holds the pipeline in stall. An access either completes or
// times out after TIMEOUT cycles.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   memRead_in, memWrite_in  load / store present in MEM
//   funct3_in                access size and signedness
//   addr_in, store_data_in   byte address, rs2 value
//   dmem_req/we/addr/wdata/be  registered request to data memory
//   dmem_rdata, dmem_ack     read word and one-cycle completion
//   dmem_read_data_out       formatted load result to MEM/WB
//   stall_out                freezes the pipeline upstream of MEM/WB
//   fault_out                misaligned/illegal access (combinational)
//   bus_error_out            one-cycle pulse on timeout
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no transaction; a legal access launches a request
// REQ   | request outstanding, waiting for ack or timeout
// DONE  | one non-stalled cycle so MEM/WB captures the result

module mem_stage_lsu #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memRead_in,
    input  logic        memWrite_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] dmem_read_data_out,
    output logic        stall_out,
    output logic        fault_out,
    output logic        bus_error_out
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       ld_f3;
    logic [1:0]       ld_off;

    logic        acc;
    logic        f3_bad;
    logic        misalign;
    logic        fault;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [31:0] shifted;
    logic [31:0] load_fmt;

    always_comb begin
        acc    = memRead_in | memWrite_in;
        f3_bad = 1'b0;
        if (memWrite_in)
            f3_bad = !(funct3_in inside {3'b000, 3'b001, 3'b010});
        else
            f3_bad = !(funct3_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misalign = 1'b0;
        case (funct3_in[1:0])
            2'b01:   misalign = addr_in[0];
            2'b10:   misalign = (addr_in[1:0] != 2'b00);
            default: misalign = 1'b0;
        endcase
        fault = acc & ((memRead_in & memWrite_in) | f3_bad | misalign);
    end

    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = store_data_in;
        case (funct3_in[1:0])
            2'b00: begin
                be_nxt    = 4'b0001 << addr_in[1:0];
                wdata_nxt = {4{store_data_in[7:0]}};
            end
            2'b01: begin
                be_nxt    = 4'b0011 << addr_in[1:0];
                wdata_nxt = {2{store_data_in[15:0]}};
            end
            default: begin
                be_nxt    = 4'b1111;
                wdata_nxt = store_data_in;
            end
        endcase
    end

    // Move the addressed lane down to bit 0, then extend per the held funct3.
    always_comb begin
        shifted  = dmem_rdata >> {ld_off, 3'b000};
        load_fmt = dmem_rdata;
        case (ld_f3)
            3'b000:  load_fmt = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_fmt = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_fmt = {24'h0, shifted[7:0]};
            3'b101:  load_fmt = {16'h0, shifted[15:0]};
            default: load_fmt = dmem_rdata;
        endcase
    end

    assign fault_out = fault;
    assign stall_out = (state == S_REQ) || ((state == S_IDLE) && acc && !fault);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            cnt                <= '0;
            ld_f3              <= 3'b000;
            ld_off             <= 2'b00;
            dmem_req           <= 1'b0;
            dmem_we            <= 1'b0;
            dmem_addr          <= 32'h0;
            dmem_wdata         <= 32'h0;
            dmem_be            <= 4'h0;
            dmem_read_data_out <= 32'h0;
            bus_error_out      <= 1'b0;
        end else begin
            bus_error_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (acc && !fault) begin
                        state      <= S_REQ;
                        cnt        <= '0;
                        dmem_req   <= 1'b1;
                        dmem_we    <= memWrite_in;
                        dmem_addr  <= {addr_in[31:2], 2'b00};
                        dmem_be    <= be_nxt;
                        dmem_wdata <= wdata_nxt;
                        ld_f3      <= funct3_in;
                        ld_off     <= addr_in[1:0];
                    end
                end
                S_REQ: begin
                    if (dmem_ack) begin
                        if (!dmem_we)
                            dmem_read_data_out <= load_fmt;
                        dmem_req <= 1'b0;
                        state    <= S_DONE;
                    end else if (cnt == CNT_LAST) begin
                        dmem_req           <= 1'b0;
                        bus_error_out      <= 1'b1;
                        dmem_read_data_out <= 32'h0;
                        state              <= S_DONE;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    logic        clk;
    logic        rst_n;
    logic        memRead_in;
    logic        memWrite_in;
    logic [2:0]  funct3_in;
    logic [31:0] addr_in;
    logic [31:0] store_data_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic [31:0] dmem_read_data_out;
    logic        stall_out;
    logic        fault_out;
    logic        bus_error_out;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage_lsu #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .memRead_in         (memRead_in),
        .memWrite_in        (memWrite_in),
        .funct3_in          (funct3_in),
        .addr_in            (addr_in),
        .store_data_in      (store_data_in),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_be            (dmem_be),
        .dmem_rdata         (dmem_rdata),
        .dmem_ack           (dmem_ack),
        .dmem_read_data_out (dmem_read_data_out),
        .stall_out          (stall_out),
        .fault_out          (fault_out),
        .bus_error_out      (bus_error_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        logic        e_fault;
        logic        e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Legal access: IDLE stall cycle, one REQ cycle acked, then DONE.
    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        memRead_in    = v.rd;
        memWrite_in   = v.wr;
        funct3_in     = v.f3;
        addr_in       = v.addr;
        store_data_in = v.sd;
        dmem_ack      = 1'b0;
        #1;
        chk({tag, ".fault"},  32'(fault_out), 32'(v.e_fault));
        chk({tag, ".stall0"}, 32'(stall_out), 32'(!v.e_fault));
        if (v.e_fault) begin
            @(negedge clk);
            #1;
            chk({tag, ".req_f"},   32'(dmem_req),  32'd0);
            chk({tag, ".stall_f"}, 32'(stall_out), 32'd0);
            chk({tag, ".data_f"},  dmem_read_data_out, v.e_data);
        end else begin
            @(negedge clk);
            #1;
            chk({tag, ".req"},    32'(dmem_req),  32'd1);
            chk({tag, ".stall1"}, 32'(stall_out), 32'd1);
            chk({tag, ".we"},     32'(dmem_we),   32'(v.e_we));
            chk({tag, ".addr"},   dmem_addr,      v.e_addr);
            chk({tag, ".be"},     32'(dmem_be),   32'(v.e_be));
            chk({tag, ".wdata"},  dmem_wdata,     v.e_wdata);
            dmem_ack   = 1'b1;
            dmem_rdata = v.rdata;
            @(negedge clk);
            dmem_ack    = 1'b0;
            dmem_rdata  = 32'h0;
            memRead_in  = 1'b0;
            memWrite_in = 1'b0;
            #1;
            chk({tag, ".req_done"},   32'(dmem_req),      32'd0);
            chk({tag, ".stall_done"}, 32'(stall_out),     32'd0);
            chk({tag, ".berr"},       32'(bus_error_out), 32'd0);
            chk({tag, ".data"},       dmem_read_data_out, v.e_data);
        end
        memRead_in  = 1'b0;
        memWrite_in = 1'b0;
    endtask

    initial begin
        int          st;
        int          reqc;
        int          berr;
        logic        fin;
        logic        berr_stall;
        logic [31:0] berr_data;
        vec_t        v;

        //           rd    wr    f3      addr        sd            rdata          flt   we    e_addr      be     e_wdata       e_data
        vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 32'h100, 4'hF, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h203, 32'h0,        32'h80112233, 1'b0, 1'b0, 32'h200, 4'h8, 32'h0,        32'hFFFFFF80};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h203, 32'h0,        32'h80112233, 1'b0, 1'b0, 32'h200, 4'h8, 32'h0,        32'h00000080};
        vecs[3]  = '{1'b1, 1'b0, 3'b001, 32'h202, 32'h0,        32'h80112233, 1'b0, 1'b0, 32'h200, 4'hC, 32'h0,        32'hFFFF8011};
        vecs[4]  = '{1'b1, 1'b0, 3'b101, 32'h202, 32'h0,        32'h80112233, 1'b0, 1'b0, 32'h200, 4'hC, 32'h0,        32'h00008011};
        vecs[5]  = '{1'b1, 1'b0, 3'b000, 32'h201, 32'h0,        32'h80112233, 1'b0, 1'b0, 32'h200, 4'h2, 32'h0,        32'h00000022};
        vecs[6]  = '{1'b0, 1'b1, 3'b000, 32'h301, 32'h000000AB, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h300, 4'h2, 32'hABABABAB, 32'h00000022};
        vecs[7]  = '{1'b0, 1'b1, 3'b001, 32'h302, 32'h00001234, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h300, 4'hC, 32'h12341234, 32'h00000022};
        vecs[8]  = '{1'b0, 1'b1, 3'b010, 32'h304, 32'hCAFEF00D, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h304, 4'hF, 32'hCAFEF00D, 32'h00000022};
        vecs[9]  = '{1'b1, 1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,   4'h0, 32'h0,        32'h00000022};
        vecs[10] = '{1'b1, 1'b0, 3'b001, 32'h101, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,   4'h0, 32'h0,        32'h00000022};
        vecs[11] = '{1'b1, 1'b1, 3'b010, 32'h100, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,   4'h0, 32'h0,        32'h00000022};
        vecs[12] = '{1'b1, 1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,   4'h0, 32'h0,        32'h00000022};
        vecs[13] = '{1'b0, 1'b1, 3'b100, 32'h100, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,   4'h0, 32'h0,        32'h00000022};
        vecs[14] = '{1'b1, 1'b0, 3'b001, 32'h106, 32'h0,        32'h7FFF0000, 1'b0, 1'b0, 32'h104, 4'hC, 32'h0,        32'h00007FFF};
        vecs[15] = '{1'b1, 1'b0, 3'b000, 32'h200, 32'h0,        32'h000000F0, 1'b0, 1'b0, 32'h200, 4'h1, 32'h0,        32'hFFFFFFF0};

        rst_n         = 1'b0;
        memRead_in    = 1'b0;
        memWrite_in   = 1'b0;
        funct3_in     = 3'b000;
        addr_in       = 32'h0;
        store_data_in = 32'h0;
        dmem_rdata    = 32'h0;
        dmem_ack      = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.req",   32'(dmem_req),      32'd0);
        chk("rst.we",    32'(dmem_we),       32'd0);
        chk("rst.addr",  dmem_addr,          32'h0);
        chk("rst.wdata", dmem_wdata,         32'h0);
        chk("rst.be",    32'(dmem_be),       32'd0);
        chk("rst.data",  dmem_read_data_out, 32'h0);
        chk("rst.berr",  32'(bus_error_out), 32'd0);
        chk("rst.stall", 32'(stall_out),     32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

        // Ack while IDLE must not disturb anything.
        @(negedge clk);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h12345678;
        @(negedge clk);
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        chk("idle_ack.data",  dmem_read_data_out, 32'hFFFFFFF0);
        chk("idle_ack.req",   32'(dmem_req),      32'd0);
        chk("idle_ack.stall", 32'(stall_out),     32'd0);

        // LW with ack in the third REQ cycle: four stall cycles; ack in DONE ignored.
        st   = 0;
        reqc = 0;
        fin  = 1'b0;
        @(negedge clk);
        memRead_in = 1'b1;
        funct3_in  = 3'b010;
        addr_in    = 32'h10C;
        for (int k = 0; k < 20 && !fin; k++) begin
            #1;
            if (stall_out) st++;
            if (dmem_req) begin
                reqc++;
                if (reqc == 3) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = 32'h01234567;
                end
            end else if (k > 0) begin
                fin = 1'b1;
                chk("dly.data", dmem_read_data_out, 32'h01234567);
                memRead_in = 1'b0;
                dmem_ack   = 1'b1;
                dmem_rdata = 32'hBAD0BAD0;
            end
            @(negedge clk);
            dmem_ack = 1'b0;
        end
        #1;
        chk("dly.finished",     32'(fin),  32'd1);
        chk("dly.stall_cycles", 32'(st),   32'd4);
        chk("dly.req_cycles",   32'(reqc), 32'd3);
        chk("dly.done_ack",     dmem_read_data_out, 32'h01234567);
        chk("dly.req_after",    32'(dmem_req),      32'd0);

        // LW with no ack: 16 REQ cycles, single bus error pulse, data cleared.
        reqc       = 0;
        berr       = 0;
        berr_data  = 32'hFFFFFFFF;
        berr_stall = 1'b1;
        @(negedge clk);
        memRead_in = 1'b1;
        funct3_in  = 3'b010;
        addr_in    = 32'h108;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (dmem_req) reqc++;
            if (bus_error_out) begin
                berr++;
                berr_data  = dmem_read_data_out;
                berr_stall = stall_out;
                memRead_in = 1'b0;
            end
        end
        chk("to.req_cycles", 32'(reqc), 32'd16);
        chk("to.berr_count", 32'(berr), 32'd1);
        chk("to.data",       berr_data, 32'h0);
        chk("to.stall",      32'(berr_stall), 32'd0);
        chk("to.req_after",  32'(dmem_req),   32'd0);

        // Back in IDLE: a fresh load issues normally.
        v = '{1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h0BADF00D, 1'b0, 1'b0, 32'h400, 4'hF, 32'h0, 32'h0BADF00D};
        run_vec(100, v);

        // Reset during REQ, then a late ack.
        @(negedge clk);
        memRead_in = 1'b1;
        funct3_in  = 3'b010;
        addr_in    = 32'h110;
        @(negedge clk);
        #1;
        chk("rmid.req_before", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n      = 1'b1;
        memRead_in = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h55555555;
        #1;
        chk("rmid.req",   32'(dmem_req),      32'd0);
        chk("rmid.stall", 32'(stall_out),     32'd0);
        chk("rmid.addr",  dmem_addr,          32'h0);
        chk("rmid.be",    32'(dmem_be),       32'd0);
        chk("rmid.we",    32'(dmem_we),       32'd0);
        chk("rmid.wdata", dmem_wdata,         32'h0);
        chk("rmid.data",  dmem_read_data_out, 32'h0);
        chk("rmid.berr",  32'(bus_error_out), 32'd0);
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        chk("rmid.late_ack_data", dmem_read_data_out, 32'h0);
        chk("rmid.late_ack_req",  32'(dmem_req),      32'd0);
        chk("rmid.late_ack_stall", 32'(stall_out),    32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
